// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locking arbiter sharing one UART byte transmitter between NUM_REQ sources.
// A grant is held until the owner's last byte transfers or the owner stalls too long.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 270000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic                 o_tx_valid,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_ready,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy,
  output logic                 o_timeout_pulse
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e              r_state;
  logic [IdxW-1:0]     r_owner;
  logic [IdxW-1:0]     r_last_owner;
  logic [NUM_REQ-1:0]  r_grant;
  logic                r_busy;
  logic                r_timeout_pulse;
  logic [CntW-1:0]     r_cnt;

  logic                w_tx_valid;
  logic [7:0]          w_tx_data;
  logic [NUM_REQ-1:0]  w_req_ready;
  logic                w_last;
  logic                w_found;
  logic [IdxW-1:0]     w_winner;

  // Datapath mux driven straight from the registered owner: no added pipeline stage.
  always_comb begin
    w_tx_valid  = 1'b0;
    w_tx_data   = 8'h00;
    w_req_ready = '0;
    w_last      = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (r_state == StLocked && r_owner == IdxW'(i)) begin
        w_tx_valid     = i_req_valid[i];
        w_tx_data      = i_req_data[8*i +: 8];
        w_req_ready[i] = i_tx_ready;
        w_last         = i_req_last[i];
      end
    end
  end

  // Search starts just after the previous owner and wraps upward.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (!w_found && i_req_valid[i] &&
            ((int'(r_last_owner) + k) % int'(NUM_REQ)) == i) begin
          w_found  = 1'b1;
          w_winner = IdxW'(i);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= StIdle;
      r_owner         <= '0;
      r_last_owner    <= IdxW'(NUM_REQ - 1);
      r_grant         <= '0;
      r_busy          <= 1'b0;
      r_timeout_pulse <= 1'b0;
      r_cnt           <= '0;
    end else begin
      r_timeout_pulse <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_found) begin
            r_state <= StLocked;
            r_owner <= w_winner;
            r_grant <= NUM_REQ'(1) << w_winner;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        StLocked: begin
          if (w_tx_valid && i_tx_ready) begin
            r_cnt <= '0;
            if (w_last) begin
              r_state      <= StIdle;
              r_last_owner <= r_owner;
              r_grant      <= '0;
              r_busy       <= 1'b0;
            end
          end else if (!w_tx_valid) begin
            if (r_cnt == CntLast) begin
              r_state         <= StIdle;
              r_last_owner    <= r_owner;
              r_grant         <= '0;
              r_busy          <= 1'b0;
              r_timeout_pulse <= 1'b1;
              r_cnt           <= '0;
            end else if (r_cnt != {CntW{1'b1}}) begin
              r_cnt <= r_cnt + CntW'(1);
            end
          end
          // Valid owner held off by the transmitter: counter holds.
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_req_ready     = w_req_ready;
  assign o_tx_valid      = w_tx_valid;
  assign o_tx_data       = w_tx_data;
  assign o_grant         = r_grant;
  assign o_busy          = r_busy;
  assign o_timeout_pulse = r_timeout_pulse;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-source byte queues feed the DUT, hand-ordered
// expected bytes are checked by an independent monitor on the transmitter side.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_pulse;

  uart_tx_arbiter #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_req_valid     (req_valid),
    .i_req_data      (req_data),
    .i_req_last      (req_last),
    .o_req_ready     (req_ready),
    .o_tx_valid      (tx_valid),
    .o_tx_data       (tx_data),
    .i_tx_ready      (tx_ready),
    .o_grant         (grant),
    .o_busy          (busy),
    .o_timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_to     = 0;
  int cnt_src [4];
  int bp_cnt   = 0;
  bit bp_mode  = 1'b0;
  bit hold3_chk = 1'b0;

  logic [8:0]  src_q [4][$];
  logic [11:0] exp_q [$];
  logic [3:0]  log_g [$];
  logic        log_v [$];
  logic [3:0]  log_r [$];
  logic        log_to [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Transmitter-side monitor: every accepted byte must match the next expected one.
  always @(negedge clk) begin
    logic [11:0] e;
    if (!rst) begin
      if (timeout_pulse) n_to++;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_byte: got grant=%b data=%h, required none", grant, tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'({grant, tx_data}), 32'(e));
          for (int i = 0; i < 4; i++) if (grant[i]) cnt_src[i]++;
        end
      end
    end
  end

  task automatic pushx(input int src, input logic [7:0] d);
    exp_q.push_back({4'(1 << src), d});
  endtask

  task automatic load(input int src, input logic [7:0] d, input logic last);
    src_q[src].push_back({last, d});
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = src_q[i][0][7:0];
        req_last[i]        = src_q[i][0][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic step();
    logic [3:0] hs;
    @(negedge clk);
    hs = req_valid & req_ready;
    log_g.push_back(grant);
    log_v.push_back(tx_valid);
    log_r.push_back(req_ready);
    log_to.push_back(timeout_pulse);
    if (bp_mode && grant == 4'b0001) chk("ready_tracks_tx_ready", 32'(req_ready), 32'(tx_ready));
    if (hold3_chk && grant == 4'b0010) chk("ready3_held_low", 32'(req_ready[3]), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (hs[i]) void'(src_q[i].pop_front());
    if (bp_mode) begin
      bp_cnt++;
      tx_ready = (bp_cnt % 234 == 0);
    end else begin
      tx_ready = 1'b1;
    end
    drive();
  endtask

  function automatic int pending();
    int p = exp_q.size();
    for (int i = 0; i < 4; i++) p += src_q[i].size();
    return p;
  endfunction

  task automatic drain(input string name, input int max);
    int n = 0;
    while (pending() != 0 && n < max) begin
      step();
      n++;
    end
    chk({"drain_", name}, 32'(pending()), 32'd0);
    step();
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_q[i].delete();
      cnt_src[i] = 0;
    end
    exp_q.delete();
    bp_mode = 1'b0;
    hold3_chk = 1'b0;
    tx_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_tx_valid", 32'(tx_valid), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_timeout", 32'(timeout_pulse), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_to = 0;
    log_g.delete();
    log_v.delete();
    log_r.delete();
    log_to.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] hello [5];
    logic [3:0] g_exp [9];
    int to_sum;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    g_exp = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
              4'b0100, 4'b0100, 4'b0100, 4'b0000};

    // Reset priority: requester 0 first, one dead cycle, then requester 2.
    do_reset();
    for (int b = 0; b < 3; b++) begin
      load(0, 8'hA0 + 8'(b), b == 2);
      load(2, 8'hC0 + 8'(b), b == 2);
    end
    for (int b = 0; b < 3; b++) pushx(0, 8'hA0 + 8'(b));
    for (int b = 0; b < 3; b++) pushx(2, 8'hC0 + 8'(b));
    drive();
    drain("reset_priority", 50);
    for (int i = 0; i < 9; i++) chk("prio_grant_seq", 32'(log_g[i]), 32'(g_exp[i]));
    chk("prio_busy_after", 32'(busy), 32'd0);

    // Round-robin fairness over 40 one-byte messages.
    do_reset();
    for (int m = 0; m < 10; m++) begin
      for (int i = 0; i < 4; i++) begin
        load(i, 8'((i << 4) | m), 1'b1);
        pushx(i, 8'((i << 4) | m));
      end
    end
    drive();
    drain("fairness", 200);
    for (int i = 0; i < 4; i++) chk("fair_share", 32'(cnt_src[i]), 32'd10);

    // No interleave: "Hello" from 1 while 3 waits.
    do_reset();
    hold3_chk = 1'b1;
    for (int b = 0; b < 5; b++) begin
      load(1, hello[b], b == 4);
      pushx(1, hello[b]);
    end
    load(3, 8'hA0, 1'b0);
    load(3, 8'hA1, 1'b1);
    pushx(3, 8'hA0);
    pushx(3, 8'hA1);
    drive();
    drain("no_interleave", 50);
    hold3_chk = 1'b0;

    // Backpressure: one byte per 234-cycle frame.
    do_reset();
    bp_mode = 1'b1;
    bp_cnt  = 0;
    for (int b = 0; b < 4; b++) begin
      load(0, 8'hB0 + 8'(b), b == 3);
      pushx(0, 8'hB0 + 8'(b));
    end
    drive();
    drain("backpressure", 2000);
    bp_mode = 1'b0;
    chk("bp_no_timeout", 32'(n_to), 32'd0);

    // Timeout: requester 2 stalls after one non-last byte; 3 is granted next.
    do_reset();
    load(2, 8'h55, 1'b0);
    load(3, 8'h77, 1'b1);
    pushx(2, 8'h55);
    pushx(3, 8'h77);
    drive();
    drain("timeout", 100);
    chk("to_pulse_before", 32'(log_to[17]), 32'd0);
    chk("to_pulse_at", 32'(log_to[18]), 32'd1);
    chk("to_pulse_after", 32'(log_to[19]), 32'd0);
    chk("to_grant_before", 32'(log_g[17]), 32'b0100);
    chk("to_grant_at", 32'(log_g[18]), 32'd0);
    chk("to_grant_next", 32'(log_g[19]), 32'b1000);
    to_sum = 0;
    foreach (log_to[i]) to_sum += int'(log_to[i]);
    chk("to_pulse_count", 32'(to_sum), 32'd1);

    // Reset during byte 2 of 5 from requester 1; arbitration restarts at 0.
    do_reset();
    load(2, 8'hB0, 1'b1);
    pushx(2, 8'hB0);
    drive();
    step();
    step();
    for (int b = 0; b < 5; b++) load(1, 8'hD0 + 8'(b), b == 4);
    pushx(1, 8'hD0);
    drive();
    step();
    step();
    rst = 1'b1;
    load(0, 8'hF0, 1'b1);
    load(3, 8'hE0, 1'b1);
    drive();
    step();
    rst = 1'b0;
    pushx(0, 8'hF0);
    for (int b = 2; b < 5; b++) pushx(1, 8'hD0 + 8'(b));
    pushx(3, 8'hE0);
    step();
    step();
    chk("rst_mid_grant", 32'(log_g[5]), 32'd0);
    chk("rst_mid_tx_valid", 32'(log_v[5]), 32'd0);
    chk("rst_mid_req_ready", 32'(log_r[5]), 32'd0);
    chk("rst_mid_regrant_0", 32'(log_g[6]), 32'b0001);
    drain("reset_mid", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
